// File: rtl/prism_aux_fabric.sv
// prism_aux_fabric: support fabric for the PRISM FSM peripheral.
//
// Holds NCNT counters (down-to-zero or up-to-preload, optional auto-reload), a
// SHIFT_W-bit serial shifter with completion detect, an output latch with a per-bit
// bypass mask and a maskable interrupt controller. FSM strobes drive the counters,
// shifter and latch. fsm_stat feeds counter/shifter status back to the FSM.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   address, data_in     bus register address / write data
//   data_write_n         2'b10 = 32-bit write, anything else does not write
//   data_read_n          unused (reads are combinational)
//   data_out, data_ready read data (unmapped = 0), always ready
//   fsm_enable           gates counter loads
//   fsm_halt             freezes every strobe-driven action
//   fsm_ctl              {latch, shift, {load_k, step_k} per counter}
//   fsm_stat             {shift_bit, done_k per counter}
//   comm_in              serial input candidates selected by CTRL.comm_sel
//   out_src, pin_out     live FSM outputs and the latched/bypassed pin outputs
//   irq                  OR of enabled pending interrupt bits
module prism_aux_fabric #(
    parameter int unsigned NCNT    = 2,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned SHIFT_W = 8,
    parameter int unsigned LATCH_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          address,
    input  logic [31:0]         data_in,
    input  logic [1:0]          data_write_n,
    input  logic [1:0]          data_read_n,
    output logic [31:0]         data_out,
    output logic                data_ready,
    input  logic                fsm_enable,
    input  logic                fsm_halt,
    input  logic [2*NCNT+1:0]   fsm_ctl,
    output logic [NCNT:0]       fsm_stat,
    input  logic [3:0]          comm_in,
    input  logic [LATCH_W-1:0]  out_src,
    output logic [LATCH_W-1:0]  pin_out,
    output logic                irq
);

    localparam int unsigned NIRQ = NCNT + 2;
    localparam int unsigned BCW  = $clog2(SHIFT_W + 1);

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_IRQ_STAT = 6'h04;
    localparam logic [5:0] ADDR_IRQ_EN   = 6'h08;
    localparam logic [5:0] ADDR_SHIFT    = 6'h0C;

    // Only implemented CTRL bits are stored, so unused bits read back as 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_0007
                                      | (((32'd1 << LATCH_W) - 32'd1) << 8)
                                      | (((32'd1 << NCNT) - 32'd1) << 16)
                                      | (((32'd1 << NCNT) - 32'd1) << 20);

    function automatic logic [5:0] cnt_addr(input int unsigned k);
        return 6'(32'd16 + 32'd4 * k);
    endfunction

    logic [31:0]                     ctrl_q, ctrl_d;
    logic [NIRQ-1:0]                 irq_stat_q, irq_stat_d;
    logic [NIRQ-1:0]                 irq_en_q, irq_en_d;
    logic [SHIFT_W-1:0]              shreg_q, shreg_d;
    logic [BCW-1:0]                  bitcnt_q, bitcnt_d;
    logic [LATCH_W-1:0]              latch_q, latch_d;
    logic                            halt_r_q;
    logic [NCNT-1:0][CNT_W-1:0]      count_q, count_d;
    logic [NCNT-1:0][CNT_W-1:0]      preload_q, preload_d;
    logic [NCNT-1:0][CNT_W-1:0]      count_inc;

    logic                            we;
    logic                            shift_dir;
    logic [1:0]                      comm_sel;
    logic [LATCH_W-1:0]              latch_mask;
    logic [NCNT-1:0]                 up_mode;
    logic [NCNT-1:0]                 autoreload;
    logic                            shift_in;
    logic                            shift_evt;
    logic [NCNT-1:0]                 cnt_evt;
    logic [NIRQ-1:0]                 irq_set, irq_clr;

    logic unused_read_n;
    assign unused_read_n = ^data_read_n;

    assign we         = (data_write_n == 2'b10);
    assign shift_dir  = ctrl_q[0];
    assign comm_sel   = ctrl_q[2:1];
    assign latch_mask = ctrl_q[8 +: LATCH_W];
    assign up_mode    = ctrl_q[16 +: NCNT];
    assign autoreload = ctrl_q[20 +: NCNT];
    assign shift_in   = comm_in[comm_sel];
    assign data_ready = 1'b1;

    // Simple bus-written registers
    always_comb begin
        ctrl_d   = ctrl_q;
        irq_en_d = irq_en_q;
        if (we && address == ADDR_CTRL)   ctrl_d   = data_in & CTRL_MASK;
        if (we && address == ADDR_IRQ_EN) irq_en_d = data_in[NIRQ-1:0];
    end

    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            count_inc[k] = count_q[k] + CNT_W'(1);
        end
    end

    // Counters: load and step together is a no-op; halt freezes everything.
    always_comb begin
        count_d   = count_q;
        preload_d = preload_q;
        cnt_evt   = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (we && address == cnt_addr(k)) preload_d[k] = data_in[CNT_W-1:0];
            if (!fsm_halt && (fsm_ctl[2*k+1] ^ fsm_ctl[2*k])) begin
                if (fsm_ctl[2*k+1]) begin
                    if (fsm_enable) count_d[k] = up_mode[k] ? '0 : preload_q[k];
                end else if (up_mode[k]) begin
                    count_d[k] = count_inc[k];
                    if (count_inc[k] == preload_q[k]) begin
                        cnt_evt[k] = 1'b1;
                        if (autoreload[k]) count_d[k] = '0;
                    end
                end else if (count_q[k] != '0) begin
                    count_d[k] = count_q[k] - CNT_W'(1);
                    if (count_q[k] == CNT_W'(1)) cnt_evt[k] = 1'b1;
                end else if (autoreload[k]) begin
                    count_d[k] = preload_q[k];
                end
            end
        end
    end

    // Shifter: a bus write to SHIFT wins over a strobe in the same cycle.
    always_comb begin
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        shift_evt = 1'b0;
        if (we && address == ADDR_SHIFT) begin
            shreg_d  = data_in[SHIFT_W-1:0];
            bitcnt_d = '0;
        end else if (!fsm_halt && fsm_ctl[2*NCNT]) begin
            shreg_d = shift_dir ? {shift_in, shreg_q[SHIFT_W-1:1]}
                                : {shreg_q[SHIFT_W-2:0], shift_in};
            if (bitcnt_q == BCW'(SHIFT_W - 1)) begin
                bitcnt_d  = '0;
                shift_evt = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + BCW'(1);
            end
        end
    end

    always_comb begin
        latch_d = latch_q;
        if (!fsm_halt && fsm_ctl[2*NCNT+1]) latch_d = out_src;
    end

    // Interrupts: a hardware set beats a write-1-to-clear of the same bit.
    always_comb begin
        irq_set             = '0;
        irq_set[0]          = fsm_halt & ~halt_r_q;
        irq_set[1]          = shift_evt;
        irq_set[NIRQ-1:2]   = cnt_evt;
        irq_clr             = (we && address == ADDR_IRQ_STAT) ? data_in[NIRQ-1:0] : '0;
        irq_stat_d          = (irq_stat_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            latch_q    <= '0;
            halt_r_q   <= 1'b0;
            count_q    <= '0;
            preload_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            latch_q    <= latch_d;
            halt_r_q   <= fsm_halt;
            count_q    <= count_d;
            preload_q  <= preload_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            fsm_stat[k] = up_mode[k] ? (count_q[k] == preload_q[k]) : (count_q[k] == '0);
        end
        fsm_stat[NCNT] = shift_dir ? shreg_q[0] : shreg_q[SHIFT_W-1];
    end

    assign pin_out = (latch_q & latch_mask) | (out_src & ~latch_mask);
    assign irq     = |(irq_stat_q & irq_en_q);

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL:     data_out = ctrl_q;
            ADDR_IRQ_STAT: data_out[NIRQ-1:0] = irq_stat_q;
            ADDR_IRQ_EN:   data_out[NIRQ-1:0] = irq_en_q;
            ADDR_SHIFT: begin
                data_out[SHIFT_W-1:0] = shreg_q;
                data_out[24 +: BCW]   = bitcnt_q;
            end
            default: ;
        endcase
        for (int k = 0; k < NCNT; k++) begin
            if (address == cnt_addr(k)) data_out[CNT_W-1:0] = count_q[k];
        end
    end

endmodule

// File: tb/tb_prism_aux_fabric.sv
// Self-checking bench for prism_aux_fabric: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_prism_aux_fabric;

    localparam int unsigned NCNT    = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SHIFT_W = 8;
    localparam int unsigned LATCH_W = 4;

    localparam logic [31:0] CTRL_MASK = 32'h0033_0F07;
    localparam logic [31:0] IRQ_MASK  = 32'h0000_000F;
    localparam logic [31:0] SH_MASK   = 32'h0000_00FF;
    localparam int unsigned LIM       = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        fsm_enable;
    logic        fsm_halt;
    logic [5:0]  fsm_ctl;
    logic [2:0]  fsm_stat;
    logic [3:0]  comm_in;
    logic [3:0]  out_src;
    logic [3:0]  pin_out;
    logic        irq;

    prism_aux_fabric #(
        .NCNT    (NCNT),
        .CNT_W   (CNT_W),
        .SHIFT_W (SHIFT_W),
        .LATCH_W (LATCH_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .fsm_enable   (fsm_enable),
        .fsm_halt     (fsm_halt),
        .fsm_ctl      (fsm_ctl),
        .fsm_stat     (fsm_stat),
        .comm_in      (comm_in),
        .out_src      (out_src),
        .pin_out      (pin_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_cnt [NCNT];
    logic [31:0] m_pre [NCNT];
    logic [31:0] m_ctrl, m_stat, m_en, m_shreg, m_bitcnt, m_latch;
    logic        m_halt_r;

    task automatic model_reset();
        for (int k = 0; k < NCNT; k++) begin
            m_cnt[k] = 0;
            m_pre[k] = 0;
        end
        m_ctrl = 0; m_stat = 0; m_en = 0; m_shreg = 0; m_bitcnt = 0; m_latch = 0;
        m_halt_r = 0;
    endtask

    // Next state from the inputs currently driven; call just before the clock edge.
    task automatic model_clock();
        logic [31:0] n_cnt [NCNT];
        logic [31:0] n_pre [NCNT];
        logic [31:0] n_ctrl, n_stat, n_en, n_shreg, n_bitcnt, n_latch, set;
        logic        we, ld, st, up, ar, bin;
        n_cnt = m_cnt; n_pre = m_pre;
        n_ctrl = m_ctrl; n_stat = m_stat; n_en = m_en;
        n_shreg = m_shreg; n_bitcnt = m_bitcnt; n_latch = m_latch;
        set = 0;
        we = (data_write_n == 2'b10);

        for (int k = 0; k < NCNT; k++) begin
            ld = fsm_ctl[2*k+1];
            st = fsm_ctl[2*k];
            up = m_ctrl[16+k];
            ar = m_ctrl[20+k];
            if (!fsm_halt && ld != st) begin
                if (ld) begin
                    if (fsm_enable) n_cnt[k] = up ? 0 : m_pre[k];
                end else if (up) begin
                    n_cnt[k] = (m_cnt[k] + 1) % LIM;
                    if (n_cnt[k] == m_pre[k]) begin
                        set = set | (32'd1 << (2 + k));
                        if (ar) n_cnt[k] = 0;
                    end
                end else if (m_cnt[k] == 0) begin
                    if (ar) n_cnt[k] = m_pre[k];
                end else begin
                    if (m_cnt[k] == 1) set = set | (32'd1 << (2 + k));
                    n_cnt[k] = m_cnt[k] - 1;
                end
            end
        end

        if (we && address == 6'h0C) begin
            n_shreg = data_in & SH_MASK;
            n_bitcnt = 0;
        end else if (!fsm_halt && fsm_ctl[4]) begin
            bin = comm_in[m_ctrl[2:1]];
            if (m_ctrl[0]) n_shreg = (m_shreg >> 1) | (32'(bin) << (SHIFT_W - 1));
            else           n_shreg = ((m_shreg << 1) | 32'(bin)) & SH_MASK;
            if (m_bitcnt + 1 == SHIFT_W) begin
                n_bitcnt = 0;
                set = set | 32'd2;
            end else begin
                n_bitcnt = m_bitcnt + 1;
            end
        end

        if (!fsm_halt && fsm_ctl[5]) n_latch = 32'(out_src);
        if (fsm_halt && !m_halt_r) set = set | 32'd1;

        if (we) begin
            case (address)
                6'h00: n_ctrl = data_in & CTRL_MASK;
                6'h04: n_stat = m_stat & ~data_in;
                6'h08: n_en = data_in & IRQ_MASK;
                6'h10: n_pre[0] = data_in % LIM;
                6'h14: n_pre[1] = data_in % LIM;
                default: ;
            endcase
        end
        n_stat = (n_stat | set) & IRQ_MASK;

        m_cnt = n_cnt; m_pre = n_pre;
        m_ctrl = n_ctrl; m_stat = n_stat; m_en = n_en;
        m_shreg = n_shreg; m_bitcnt = n_bitcnt; m_latch = n_latch;
        m_halt_r = fsm_halt;
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        case (a)
            6'h00:   return m_ctrl;
            6'h04:   return m_stat;
            6'h08:   return m_en;
            6'h0C:   return (m_bitcnt << 24) | m_shreg;
            6'h10:   return m_cnt[0];
            6'h14:   return m_cnt[1];
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] exp_stat();
        logic [2:0] s;
        for (int k = 0; k < NCNT; k++) begin
            s[k] = m_ctrl[16+k] ? (m_cnt[k] == m_pre[k]) : (m_cnt[k] == 0);
        end
        s[2] = m_ctrl[0] ? m_shreg[0] : m_shreg[SHIFT_W-1];
        return s;
    endfunction

    function automatic logic [3:0] exp_pin();
        logic [3:0] mask;
        mask = m_ctrl[11:8];
        return (m_latch[3:0] & mask) | (out_src & ~mask);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        cycle();
        data_write_n = 2'b11;
    endtask

    task automatic strobe(input logic [5:0] ctl, input int n);
        fsm_ctl = ctl;
        repeat (n) cycle();
        fsm_ctl = '0;
    endtask

    task automatic rd_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  ctl;
        logic [5:0]  raddr;
        logic [31:0] exp_rd;
        logic [2:0]  exp_stat;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit w, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [5:0] ctl, input logic [5:0] ra, input logic [31:0] er,
                       input logic [2:0] es, input bit ei);
        vec_t v;
        v.wr = w; v.waddr = wa; v.wdata = wd; v.ctl = ctl;
        v.raddr = ra; v.exp_rd = er; v.exp_stat = es; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    localparam logic [5:0] LD0 = 6'b000010;
    localparam logic [5:0] ST0 = 6'b000001;
    localparam logic [5:0] NOP = 6'b000000;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ra;
        logic       b;

        // Down counter, preload 3
        add(1, 6'h10, 32'd3, NOP, 6'h10, 32'd0, 3'b011, 0);
        add(0, 6'h00, 32'd0, LD0, 6'h10, 32'd3, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd2, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd1, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h04, 32'h4, 3'b011, 0);
        add(1, 6'h08, 32'h4, NOP, 6'h08, 32'h4, 3'b011, 1);
        add(1, 6'h04, 32'h4, NOP, 6'h04, 32'h0, 3'b011, 0);
        // Down counter with autoreload, preload 2
        add(1, 6'h00, 32'h0010_0000, NOP, 6'h00, 32'h0010_0000, 3'b011, 0);
        add(1, 6'h10, 32'd2, NOP, 6'h10, 32'd0, 3'b011, 0);
        add(0, 6'h00, 32'd0, LD0, 6'h10, 32'd2, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd1, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h04, 32'h4, 3'b011, 1);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd2, 3'b010, 1);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd1, 3'b010, 1);
        add(1, 6'h04, 32'h4, NOP, 6'h04, 32'h0, 3'b010, 0);
        // Up counter with autoreload, preload 5 (write and load in one cycle)
        add(1, 6'h00, 32'h0011_0000, NOP, 6'h00, 32'h0011_0000, 3'b010, 0);
        add(1, 6'h10, 32'd5, LD0, 6'h10, 32'd0, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd1, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd2, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd3, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd4, 3'b010, 0);
        add(0, 6'h00, 32'd0, ST0, 6'h10, 32'd0, 3'b010, 1);
        add(1, 6'h04, 32'h4, NOP, 6'h04, 32'h0, 3'b010, 0);

        rst_n = 1'b0;
        address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        fsm_enable = 1'b1; fsm_halt = 1'b0; fsm_ctl = '0; comm_in = '0; out_src = 4'hA;
        model_reset();
        #12;
        check("rst stat", 32'(fsm_stat), 32'h3);
        check("rst irq", 32'(irq), 32'h0);
        check("rst pin_out", 32'(pin_out), 32'hA);
        check("rst ready", 32'(data_ready), 32'h1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 6; a++) rd_check($sformatf("rst rd%0d", a), 6'(4 * a), 32'h0);

        foreach (vecs[i]) begin
            address = vecs[i].waddr;
            data_in = vecs[i].wdata;
            data_write_n = vecs[i].wr ? 2'b10 : 2'b11;
            fsm_ctl = vecs[i].ctl;
            cycle();
            data_write_n = 2'b11;
            fsm_ctl = '0;
            address = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d rd", i), data_out, vecs[i].exp_rd);
            check($sformatf("vec%0d stat", i), 32'(fsm_stat), 32'(vecs[i].exp_stat));
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Up counter without autoreload wraps modulo 2^CNT_W
        wr(6'h00, 32'h0001_0000);
        strobe(ST0, 5);
        rd_check("up cnt5", 6'h10, 32'd5);
        check("up done", 32'(fsm_stat), 32'h3);
        rd_check("up evt", 6'h04, 32'h4);
        strobe(ST0, 11);
        rd_check("up wrap", 6'h10, 32'd0);
        check("up wrap stat", 32'(fsm_stat), 32'h2);
        wr(6'h04, 32'h4);

        // Shifter: 0xA5 MSB-first through comm_sel 2, left
        wr(6'h00, 32'h0000_0004);
        for (int i = 0; i < 8; i++) begin
            b = (8'hA5 >> (7 - i)) & 8'h1;
            comm_in = b ? 4'b0100 : 4'b1011;
            fsm_ctl = 6'b010000;
            cycle();
            fsm_ctl = '0;
            if (i == 6) rd_check("sh bit7", 6'h0C, 32'h0700_0052);
        end
        rd_check("sh done", 6'h0C, 32'h0000_00A5);
        rd_check("sh irq", 6'h04, 32'h2);
        check("sh bit", 32'(fsm_stat[2]), 32'h1);
        wr(6'h04, 32'h2);
        address = 6'h0C; data_in = 32'h3C; data_write_n = 2'b10; fsm_ctl = 6'b010000;
        cycle();
        data_write_n = 2'b11; fsm_ctl = '0;
        rd_check("sh wr prio", 6'h0C, 32'h0000_003C);

        // Halt freezes every strobe; halt edge sets IRQ bit 0 once
        strobe(LD0, 1);
        wr(6'h00, 32'h0000_0504);
        out_src = 4'hF; comm_in = 4'hF;
        fsm_halt = 1'b1; fsm_ctl = 6'b110101;
        cycle();
        rd_check("halt edge", 6'h04, 32'h1);
        address = 6'h04; data_in = 32'h1; data_write_n = 2'b10;
        cycle();
        data_write_n = 2'b11;
        cycle();
        fsm_halt = 1'b0; fsm_ctl = '0;
        cycle();
        rd_check("halt cnt", 6'h10, 32'd5);
        rd_check("halt sh", 6'h0C, 32'h0000_003C);
        rd_check("halt once", 6'h04, 32'h0);
        check("halt pin", 32'(pin_out), 32'hA);
        strobe(6'b000011, 1);
        rd_check("ld+st", 6'h10, 32'd5);

        // Latch with bypass mask 0x5
        out_src = 4'hF;
        strobe(6'b100000, 1);
        out_src = 4'h0;
        #1;
        check("latch pin", 32'(pin_out), 32'h5);

        // Set beats clear in the same cycle
        strobe(ST0, 4);
        address = 6'h04; data_in = 32'h4; data_write_n = 2'b10; fsm_ctl = ST0;
        cycle();
        data_write_n = 2'b11; fsm_ctl = '0;
        rd_check("set>clr", 6'h04, 32'h4);
        check("set>clr irq", 32'(irq), 32'h1);

        // Randomized run against the model, with an asynchronous reset mid-way
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                wr(6'h00, 32'h0000_0F07);
                fsm_ctl = '0; fsm_halt = 1'b0; data_write_n = 2'b11; address = 6'h00;
                #2 rst_n = 1'b0;
                #1;
                check("arst ctrl", data_out, 32'h0);
                check("arst stat", 32'(fsm_stat), 32'h3);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                cycle();
            end
            fsm_ctl = 6'($urandom);
            fsm_enable = ($urandom_range(0, 7) != 0);
            fsm_halt = ($urandom_range(0, 9) == 0);
            comm_in = 4'($urandom);
            out_src = 4'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(4 * $urandom_range(0, 9));
            address = ra;
            data_in = $urandom;
            data_write_n = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom);
            #1;
            check($sformatf("rnd%0d rd@%0h", i, ra), data_out, exp_read(ra));
            check($sformatf("rnd%0d stat", i), 32'(fsm_stat), 32'(exp_stat()));
            check($sformatf("rnd%0d irq", i), 32'(irq), 32'(|(m_stat & m_en)));
            check($sformatf("rnd%0d pin", i), 32'(pin_out), 32'(exp_pin()));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
